// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ecc_pkg
// Purpose : Shared constants and state encoding for the GF(2^233)
//           Montgomery-ladder scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package ecc_pkg;

    localparam int ECC_N         = 233;   // scalar width for GF(2^233)
    localparam int DEF_IDX_W     = 8;     // 2^8 > 233
    localparam int DEF_MAX_RETRY = 3;
    localparam int DEF_TIMEOUT   = 1023;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SCAN  = 4'd1,
        ST_INIT  = 4'd2,
        ST_ISSUE = 4'd3,
        ST_WAIT  = 4'd4,
        ST_EVAL  = 4'd5,
        ST_DONE  = 4'd6,
        ST_FAIL  = 4'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ladder_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : ladder_sched_if
// Purpose : Handshake bundle between the ladder scheduler and its
//           environment (host start, point-unit handshakes, register-file
//           control).
// Modports: master - host/datapath side (drives start, K, unit completions)
//           slave  - scheduler side
// Revision: 1.0 - initial release
// ============================================================================
interface ladder_sched_if
    import ecc_pkg::*;
#(
    parameter int N     = ECC_N,
    parameter int IDX_W = DEF_IDX_W
);
    logic             in_valid;
    logic [N-1:0]     k;
    logic             busy;
    logic             load_init;
    logic             add_in_valid;
    logic             dbl_in_valid;
    logic             add_out_valid;
    logic             dbl_out_valid;
    logic             fault;
    logic             swap;
    logic             commit;
    logic [IDX_W-1:0] step_idx;
    logic             out_valid;
    logic             inf;
    logic             error;

    modport master (
        output in_valid, k, add_out_valid, dbl_out_valid, fault,
        input  busy, load_init, add_in_valid, dbl_in_valid, swap, commit,
               step_idx, out_valid, inf, error
    );

    modport slave (
        input  in_valid, k, add_out_valid, dbl_out_valid, fault,
        output busy, load_init, add_in_valid, dbl_in_valid, swap, commit,
               step_idx, out_valid, inf, error
    );

endinterface
`default_nettype wire

// File: rtl/ladder_join.sv
`default_nettype none
// ============================================================================
// Module  : ladder_join
// Purpose : Joins the add-unit and double-unit completion pulses of one
//           ladder step and accumulates the multiplier fault flag.
// Ports   : clk, rst_n      - clock, async active-low reset
//           clr             - synchronous clear (scheduler in ISSUE)
//           en              - collect enable (scheduler in WAIT)
//           add_ov, dbl_ov  - unit completion pulses
//           fault           - multiplier error flag
//           both_done       - both units finished (includes arrival cycle)
//           fault_seen      - a fault was seen during this attempt
// Revision: 1.0 - initial release
// ============================================================================
module ladder_join (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    input  wire logic add_ov,
    input  wire logic dbl_ov,
    input  wire logic fault,
    output logic      both_done,
    output logic      fault_seen
);

    logic add_done_q, add_done_d;
    logic dbl_done_q, dbl_done_d;
    logic fault_q,    fault_d;

    always_comb begin
        add_done_d = add_done_q;
        dbl_done_d = dbl_done_q;
        fault_d    = fault_q;
        if (clr) begin
            add_done_d = 1'b0;
            dbl_done_d = 1'b0;
            fault_d    = 1'b0;
        end else if (en) begin
            add_done_d = add_done_q | add_ov;
            dbl_done_d = dbl_done_q | dbl_ov;
            fault_d    = fault_q | fault;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_done_q <= 1'b0;
            dbl_done_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            add_done_q <= add_done_d;
            dbl_done_q <= dbl_done_d;
            fault_q    <= fault_d;
        end
    end

    // Pulses arriving this cycle count, so the step can leave WAIT at once.
    assign both_done  = en & (add_done_q | add_ov) & (dbl_done_q | dbl_ov);
    assign fault_seen = fault_q;

endmodule
`default_nettype wire

// File: rtl/ladder_sched.sv
`default_nettype none
// ============================================================================
// Module  : ladder_sched
// Purpose : Montgomery-ladder step scheduler for GF(2^233) scalar
//           multiplication. Finds the leading 1 of K, loads the initial
//           ladder pair, then for each lower bit launches add + double in
//           parallel, waits for both, and commits (or retries on fault).
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - ladder_sched_if.slave (start/K, unit handshakes,
//                    SWAP/COMMIT/STEP_IDX, OUT_VALID/INF/ERROR, BUSY)
// Options : LADDER_TIMEOUT_EN - per-step WAIT watchdog (TIMEOUT cycles)
// Revision: 1.0 - initial release
// ============================================================================
module ladder_sched
    import ecc_pkg::*;
#(
    parameter int N         = ECC_N,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int MAX_RETRY = DEF_MAX_RETRY
`ifdef LADDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = DEF_TIMEOUT
`endif
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    ladder_sched_if.slave  bus
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [N-1:0]     kreg_q,  kreg_d;
    logic [IDX_W-1:0] step_q,  step_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             inf_q,   inf_d;
    logic             err_q,   err_d;
`ifdef LADDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]  wd_q,    wd_d;
`endif

    logic         join_clr;
    logic         both_done;
    logic         fault_seen;
    logic [N-1:0] kreg_shift;
    logic         key_bit;

    // Shift rather than index so the index width never has to match N.
    assign kreg_shift = kreg_q >> step_q;
    assign key_bit    = kreg_shift[0];

    ladder_join u_join (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (join_clr),
        .en         (state_q == ST_WAIT),
        .add_ov     (bus.add_out_valid),
        .dbl_ov     (bus.dbl_out_valid),
        .fault      (bus.fault),
        .both_done  (both_done),
        .fault_seen (fault_seen)
    );

    always_comb begin
        state_d  = state_q;
        kreg_d   = kreg_q;
        step_d   = step_q;
        retry_d  = retry_q;
        inf_d    = inf_q;
        err_d    = err_q;
        join_clr = 1'b0;
`ifdef LADDER_TIMEOUT_EN
        wd_d     = wd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    kreg_d  = bus.k;
                    err_d   = 1'b0;
                    inf_d   = 1'b0;
                    step_d  = IDX_W'(N - 1);
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (key_bit) begin
                    state_d = ST_INIT;
                end else if (step_q == '0) begin
                    inf_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q - IDX_W'(1);
                end
            end
            ST_INIT: begin
                if (step_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q - IDX_W'(1);
                    retry_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                join_clr = 1'b1;
`ifdef LADDER_TIMEOUT_EN
                wd_d     = '0;
`endif
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (both_done) begin
                    state_d = ST_EVAL;
                end
`ifdef LADDER_TIMEOUT_EN
                // The last allowed WAIT cycle is the TIMEOUT-th one.
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = ST_FAIL;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            ST_EVAL: begin
                if (!fault_seen) begin
                    if (step_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_q - IDX_W'(1);
                        retry_d = '0;
                        state_d = ST_ISSUE;
                    end
                end else if (retry_q < MAX_RETRY_C) begin
                    retry_d = retry_q + RW'(1);
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kreg_q  <= '0;
            step_q  <= '0;
            retry_q <= '0;
            inf_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef LADDER_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            kreg_q  <= kreg_d;
            step_q  <= step_d;
            retry_q <= retry_d;
            inf_q   <= inf_d;
            err_q   <= err_d;
`ifdef LADDER_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Outputs decode the state register, so an async reset clears them at once.
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.load_init    = (state_q == ST_INIT);
    assign bus.add_in_valid = (state_q == ST_ISSUE);
    assign bus.dbl_in_valid = (state_q == ST_ISSUE);
    assign bus.swap         = key_bit & ((state_q == ST_ISSUE) |
                                         (state_q == ST_WAIT)  |
                                         (state_q == ST_EVAL));
    assign bus.commit       = (state_q == ST_EVAL) & ~fault_seen;
    assign bus.step_idx     = step_q;
    assign bus.out_valid    = (state_q == ST_DONE) | (state_q == ST_FAIL);
    assign bus.inf          = inf_q;
    // Raised in the FAIL cycle itself so ERROR is valid alongside OUT_VALID.
    assign bus.error        = err_q | (state_q == ST_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_ladder_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_ladder_sched
// Purpose : Self-checking bench for ladder_sched (N=8, MAX_RETRY=3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ladder_sched;

    localparam int N         = 8;
    localparam int IDX_W     = 4;
    localparam int MAX_RETRY = 3;
`ifdef LADDER_TIMEOUT_EN
    localparam int TIMEOUT   = 20;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ladder_sched_if #(.N(N), .IDX_W(IDX_W)) bus ();

    ladder_sched #(
        .N         (N),
        .IDX_W     (IDX_W),
        .MAX_RETRY (MAX_RETRY)
`ifdef LADDER_TIMEOUT_EN
        ,
        .TIMEOUT   (TIMEOUT)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] k;
        int           alat;
        int           dlat;
        logic [31:0]  fplan;      // bit i: FAULT during attempt i
        bit           inj;        // second IN_VALID during first WAIT
        int           exp_lat;    // cycles from start to OUT_VALID
        bit           exp_inf;
        bit           exp_err;
        int           exp_loads;
        int           exp_commits;
        logic [31:0]  exp_swaps;  // bit j: SWAP at commit j
        int           exp_issues;
        int           exp_top;    // STEP_IDX of first commit
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [N-1:0] k, input int alat, input int dlat,
                                input logic [31:0] fplan, input bit inj, input int lat,
                                input bit inf, input bit err, input int loads,
                                input int commits, input logic [31:0] swaps,
                                input int issues, input int top);
        vec_t v;
        v.k = k; v.alat = alat; v.dlat = dlat; v.fplan = fplan; v.inj = inj;
        v.exp_lat = lat; v.exp_inf = inf; v.exp_err = err; v.exp_loads = loads;
        v.exp_commits = commits; v.exp_swaps = swaps; v.exp_issues = issues;
        v.exp_top = top;
        return v;
    endfunction

    // Ladder cost model: scan from bit N-1 down to the MSB, one INIT,
    // each attempt costs ISSUE + slower unit + EVAL, then one DONE/FAIL.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   msb, step, att, retry, w;
        bit   ok;
        r   = v;
        msb = -1;
        for (int i = 0; i < N; i++) if (v.k[i]) msb = i;
        w = (v.alat > v.dlat) ? v.alat : v.dlat;
        r.exp_swaps = '0; r.exp_commits = 0; r.exp_err = 0; r.exp_issues = 0;
        r.exp_top = msb - 1;
        r.exp_inf = (msb < 0);
        r.exp_loads = (msb < 0) ? 0 : 1;
        if (msb < 0) begin
            r.exp_lat = N + 1;
            return r;
        end
        r.exp_lat = N - msb + 1;
        att  = 0;
        step = msb - 1;
        while (step >= 0 && !r.exp_err) begin
            retry = 0;
            ok    = 0;
            while (!ok && !r.exp_err) begin
                r.exp_lat += 2 + w;
                if (att < 32 && v.fplan[att]) begin
                    if (retry == MAX_RETRY) r.exp_err = 1;
                    else retry++;
                end else begin
                    r.exp_swaps[r.exp_commits] = v.k[step];
                    r.exp_commits++;
                    ok = 1;
                end
                att++;
            end
            step--;
        end
        r.exp_lat += 1;
        r.exp_issues = att;
        return r;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int cyc = 0, loads = 0, commits = 0, issues = 0, acnt = 0, dcnt = 0;
        bit first_wait = 0, done = 0, busy_ok = 1, got_inf = 0, got_err = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.k        = v.k;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!done && cyc < 3000) begin
            cyc++;
            bus.add_out_valid = 1'b0;
            bus.dbl_out_valid = 1'b0;
            bus.fault         = 1'b0;
            bus.in_valid      = 1'b0;
            if (!bus.busy) busy_ok = 0;
            if (bus.load_init) loads++;
            if (bus.commit) begin
                chk({tag, " swap"}, bus.swap, v.exp_swaps[commits]);
                chk({tag, " commit idx"}, bus.step_idx, v.exp_top - commits);
                commits++;
            end
            if (bus.add_in_valid) begin
                acnt = v.alat;
                dcnt = v.dlat;
                issues++;
                first_wait = 1;
            end else begin
                if (acnt > 0) begin acnt--; if (acnt == 0) bus.add_out_valid = 1'b1; end
                if (dcnt > 0) begin dcnt--; if (dcnt == 0) bus.dbl_out_valid = 1'b1; end
                if (first_wait) begin
                    first_wait = 0;
                    if (issues <= 32 && v.fplan[issues-1]) bus.fault = 1'b1;
                    if (v.inj && issues == 1) begin
                        bus.in_valid = 1'b1;
                        bus.k        = ~v.k;
                    end
                end
            end
            if (bus.out_valid) begin
                done    = 1;
                got_inf = bus.inf;
                got_err = bus.error;
            end else begin
                @(negedge clk);
            end
        end
        chk({tag, " completed"}, done, 1);
        if (done) begin
            chk({tag, " latency"}, cyc, v.exp_lat);
            chk({tag, " inf"}, got_inf, v.exp_inf);
            chk({tag, " error"}, got_err, v.exp_err);
            chk({tag, " load_init count"}, loads, v.exp_loads);
            chk({tag, " commit count"}, commits, v.exp_commits);
            chk({tag, " issue count"}, issues, v.exp_issues);
            chk({tag, " busy held"}, busy_ok, 1);
            @(negedge clk);
            bus.add_out_valid = 1'b0;
            bus.dbl_out_valid = 1'b0;
            bus.fault         = 1'b0;
            chk({tag, " out_valid pulse"}, bus.out_valid, 0);
            chk({tag, " idle busy"}, bus.busy, 0);
            chk({tag, " error sticky"}, bus.error, v.exp_err);
        end
    endtask

    vec_t tbl[12];

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        bus.in_valid = 0; bus.k = '0;
        bus.add_out_valid = 0; bus.dbl_out_valid = 0; bus.fault = 0;

        //         k      al dl fplan  inj lat inf err ld cm swaps  iss top
        tbl[0]  = mk(8'h0B, 5, 5, 32'h0, 0, 28, 0, 0, 1, 3, 32'h6,  3,  2);
        tbl[1]  = mk(8'h00, 1, 1, 32'h0, 0,  9, 1, 0, 0, 0, 32'h0,  0, -1);
        tbl[2]  = mk(8'h01, 1, 1, 32'h0, 0, 10, 0, 0, 1, 0, 32'h0,  0, -1);
        tbl[3]  = mk(8'h03, 3, 1, 32'h0, 0, 14, 0, 0, 1, 1, 32'h1,  1,  0);
        tbl[4]  = mk(8'h03, 2, 2, 32'h0, 0, 13, 0, 0, 1, 1, 32'h1,  1,  0);
        tbl[5]  = mk(8'h03, 1, 4, 32'h0, 0, 15, 0, 0, 1, 1, 32'h1,  1,  0);
        tbl[6]  = mk(8'h05, 2, 3, 32'h1, 0, 23, 0, 0, 1, 2, 32'h2,  3,  1);
        tbl[7]  = mk(8'h05, 1, 1, 32'hF, 0, 20, 0, 1, 1, 0, 32'h0,  4,  1);
        tbl[8]  = mk(8'h80, 1, 2, 32'h0, 0, 31, 0, 0, 1, 7, 32'h0,  7,  6);
        tbl[9]  = mk(8'hFF, 4, 4, 32'h0, 0, 45, 0, 0, 1, 7, 32'h7F, 7,  6);
        tbl[10] = mk(8'h05, 1, 1, 32'h7, 0, 23, 0, 0, 1, 2, 32'h2,  5,  1);
        tbl[11] = mk(8'h05, 6, 6, 32'h0, 1, 24, 0, 0, 1, 2, 32'h2,  2,  1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy", bus.busy, 0);
        chk("reset load_init", bus.load_init, 0);
        chk("reset add_in_valid", bus.add_in_valid, 0);
        chk("reset dbl_in_valid", bus.dbl_in_valid, 0);
        chk("reset commit", bus.commit, 0);
        chk("reset swap", bus.swap, 0);
        chk("reset step_idx", bus.step_idx, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset inf", bus.inf, 0);
        chk("reset error", bus.error, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset busy", bus.busy, 0);

        for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted mid-WAIT
        @(negedge clk);
        bus.in_valid = 1'b1; bus.k = 8'h0B;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.add_in_valid && cnt < 50) begin @(negedge clk); cnt++; end
        chk("rstseq issue seen", bus.add_in_valid, 1);
        @(negedge clk);
        @(negedge clk);
        chk("rstseq busy in wait", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstseq async busy", bus.busy, 0);
        chk("rstseq async step_idx", bus.step_idx, 0);
        chk("rstseq async swap", bus.swap, 0);
        chk("rstseq async commit", bus.commit, 0);
        chk("rstseq async out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            bus.add_out_valid = (c == 2);
            bus.dbl_out_valid = (c == 2);
            @(negedge clk);
            if (bus.commit || bus.busy || bus.out_valid) cnt++;
        end
        bus.add_out_valid = 1'b0;
        bus.dbl_out_valid = 1'b0;
        chk("rstseq quiet after release", cnt, 0);
        run_op(tbl[0], "after-reset");

`ifdef LADDER_TIMEOUT_EN
        // Units never respond: watchdog forces FAIL
        @(negedge clk);
        bus.in_valid = 1'b1; bus.k = 8'h03;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.add_in_valid && cnt < 50) begin @(negedge clk); cnt++; end
        chk("wdog issue seen", bus.add_in_valid, 1);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!bus.out_valid && cnt < 100);
        chk("wdog fail latency", cnt, 21);
        chk("wdog error", bus.error, 1);
        @(negedge clk);
        bus.add_out_valid = 1'b1;
        bus.dbl_out_valid = 1'b1;
        @(negedge clk);
        bus.add_out_valid = 1'b0;
        bus.dbl_out_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.commit || bus.busy || bus.out_valid) cnt++;
            @(negedge clk);
        end
        chk("wdog late response ignored", cnt, 0);
        chk("wdog error held", bus.error, 1);
`endif

        // Randomized operations against the ladder cost model
        for (int i = 0; i < 40; i++) begin
            vec_t        v;
            logic [31:0] rnd;
            rnd     = $urandom;
            v.k     = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 3)) : rnd[N-1:0];
            v.alat  = $urandom_range(1, 6);
            v.dlat  = $urandom_range(1, 6);
            v.inj   = 0;
            v.fplan = '0;
            for (int b = 0; b < 32; b++) if ($urandom_range(0, 4) == 0) v.fplan[b] = 1'b1;
            if ($urandom_range(0, 5) == 0) v.fplan = v.fplan | (32'hF << $urandom_range(0, 6));
            v = model(v);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ladder_sched.md
Name: ladder_sched

Overview:
- Montgomery-ladder scheduler for GF(2^233) scalar multiplication.
- Walks scalar K from its leading 1 downward. For each remaining bit it launches one point-add unit and one point-double unit in parallel, then waits for both to finish.
- Tells the register file which ladder pair to update (SWAP) and when to commit (COMMIT).
- Retries a step when the fault-detecting multiplier flags an error.

Parameters:
- N, 233, scalar width in bits.
- IDX_W, 8, bit-index width; must satisfy 2^IDX_W > N.
- MAX_RETRY, 3, maximum retries per step before a hard fail.
- TIMEOUT, 1023, watchdog cycle limit per step (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  one-cycle start pulse; K is sampled in the same cycle.
- K  in  N  scalar.
- BUSY  out  1  high from the cycle after accepted IN_VALID until the cycle OUT_VALID is high.
- LOAD_INIT  out  1  pulse: datapath loads P1=P, P2=2P.
- ADD_IN_VALID  out  1  pulse: start point add.
- DBL_IN_VALID  out  1  pulse: start point double.
- ADD_OUT_VALID  in  1  add-unit completion pulse.
- DBL_OUT_VALID  in  1  double-unit completion pulse.
- FAULT  in  1  multiplier ERROR; sampled only in WAIT.
- SWAP  out  1  current key bit.
  - SWAP=1: P1<=P1+P2, P2<=2P2.
  - SWAP=0: P2<=P1+P2, P1<=2P1.
- COMMIT  out  1  pulse: datapath writes both results using SWAP.
- STEP_IDX  out  IDX_W  bit index currently being processed.
- OUT_VALID  out  1  one-cycle completion pulse.
- INF  out  1  valid with OUT_VALID: result is the point at infinity (K==0).
- ERROR  out  1  sticky fail flag; cleared by the next accepted IN_VALID.

Behaviour:
- Reset values: all outputs 0; STEP_IDX=0; state IDLE. Reset asserted mid-operation aborts immediately; no partial COMMIT is emitted.
- States:
  - IDLE, SCAN, INIT, ISSUE, WAIT, EVAL, DONE, FAIL.
- IDLE:
  - IN_VALID latches K into kreg, clears ERROR and INF, sets STEP_IDX=N-1, and moves to SCAN.
  - IN_VALID is ignored in every other state.
- SCAN (leading-1 search, one bit per cycle):
  - kreg[STEP_IDX]==1: go to INIT.
  - Otherwise, STEP_IDX==0 (K==0): set INF=1 and go to DONE.
  - Otherwise: decrement STEP_IDX.
  - Latency is N-1-msb+1 cycles.
- INIT:
  - LOAD_INIT=1 for one cycle.
  - STEP_IDX==0 (K==1): go to DONE.
  - Otherwise: STEP_IDX--, clear retry count, go to ISSUE.
- ISSUE:
  - ADD_IN_VALID=DBL_IN_VALID=1 for one cycle; SWAP=kreg[STEP_IDX].
  - Clear add_done, dbl_done and fault_seen; go to WAIT.
- WAIT:
  - Each *_OUT_VALID sets its done flag. The two may arrive in either order or in the same cycle.
  - FAULT=1 on any WAIT cycle sets fault_seen.
  - When both done flags are set (including the arrival cycle), go to EVAL.
  - OUT_VALIDs outside WAIT are ignored.
- EVAL:
  - fault_seen==0:
    - COMMIT=1 for one cycle.
    - STEP_IDX==0: go to DONE.
    - Otherwise: STEP_IDX--, retry=0, go to ISSUE.
  - fault_seen==1 and retry<MAX_RETRY: retry++, no COMMIT, STEP_IDX unchanged, go to ISSUE.
  - fault_seen==1 and retry==MAX_RETRY: go to FAIL.
- DONE: OUT_VALID=1 for one cycle, then IDLE.
- FAIL: ERROR<=1, OUT_VALID=1 for one cycle, then IDLE. ERROR holds until the next accepted IN_VALID.
- SWAP holds kreg[STEP_IDX] from ISSUE through EVAL, so it is stable during COMMIT.
- Cycle cost per clean step: 1 ISSUE + unit latency + 1 EVAL.

Optional Feature:
- Macro: LADDER_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears in ISSUE and increments each WAIT cycle.
  - Reaching TIMEOUT with either done flag still clear forces FAIL (ERROR=1, OUT_VALID pulse).
  - Late OUT_VALIDs that arrive afterwards are ignored.
- Undefined: no counter; WAIT can block indefinitely.

Decomposition:
- Shared package ecc_pkg holds:
  - state localparams (IDLE..FAIL, 4-bit);
  - N=233;
  - default MAX_RETRY and TIMEOUT.
- One sub-module, ladder_join:
  - collects ADD_OUT_VALID, DBL_OUT_VALID and FAULT into both_done/fault_seen;
  - has a synchronous clear from ISSUE.
- Everything else stays in ladder_sched.

Test Plan (bench overrides N=8 unless noted):
- K=8'b0000_1011, units respond after 5 cycles, FAULT=0:
  - SCAN stops at idx 3;
  - LOAD_INIT pulses once;
  - 3 COMMITs with SWAP sequence 0,1,1;
  - OUT_VALID pulses, INF=0, ERROR=0.
- K=0: OUT_VALID with INF=1 after 8 SCAN cycles; no LOAD_INIT, no COMMIT. K=1: exactly one LOAD_INIT, zero COMMITs, OUT_VALID.
- Response ordering, K=8'h03:
  - step A: DBL_OUT_VALID 2 cycles before ADD_OUT_VALID;
  - step B: both in the same cycle;
  - each step yields exactly one COMMIT, and STEP_IDX reaches 0.
- Fault retry:
  - FAULT pulses once in WAIT of the first step (K=8'h05): one re-ISSUE at the same STEP_IDX, no COMMIT for that attempt, final OUT_VALID with ERROR=0.
  - FAULT on 4 consecutive attempts (MAX_RETRY=3): FAIL, ERROR=1, OUT_VALID pulses, zero COMMITs.
- Busy behaviour and reset: a second IN_VALID during WAIT is ignored (kreg unchanged). RST_N low mid-WAIT: all outputs 0 asynchronously, state IDLE, no COMMIT after release.
- With LADDER_TIMEOUT_EN, TIMEOUT=20, units never respond: FAIL 21 cycles after ISSUE, ERROR=1; an ADD_OUT_VALID arriving afterwards is ignored.
